slice_pulse_gen: RTL and testbench

Transmit side of the single-bit slice event interface: accepts a requested slice count (0-16) through a start/ready handshake and emits exactly that many `slice` pulses with a configurable pulse width and gap. A downstream slice counter that increments once per pulse sees the requested count. Used to replay or auto-generate cuts, and as a stimulus source for the counting path.

---
 rtl/slice_pkg.sv | 20 ++
 rtl/slice_phase_timer.sv | 28 ++
 rtl/slice_pulse_gen.sv | 138 +++++++++++++
 tb/tb_slice_pulse_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared definitions for the slice event interface (generator and counter side).
package slice_pkg;

    localparam int SLICE_MAX = 16;
    localparam int SLICE_W   = 5;
    localparam int PHASE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } slice_gen_state_t;

    // Requested counts above SLICE_MAX saturate rather than wrap.
    function automatic logic [SLICE_W-1:0] clamp_count(input logic [SLICE_W-1:0] c);
        return (c > SLICE_W'(SLICE_MAX)) ? SLICE_W'(SLICE_MAX) : c;
    endfunction

endpackage

// File: rtl/slice_phase_timer.sv
// Loadable 4-bit down-counter timing the pulse and gap phases.
// A load of length L makes last_o high on the L-th cycle after the load edge.
module slice_phase_timer
    import slice_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [PHASE_W-1:0] len_i,
    output logic               last_o
);

    logic [PHASE_W-1:0] cnt_q;

    // Reload to len-1 on phase entry, then count down and rest at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= len_i - PHASE_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - PHASE_W'(1);
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/slice_pulse_gen.sv
// Slice pulse generator: emits a requested number of slice pulses with a
// programmable high time and gap, then a one-cycle done strobe.
// Optional macro SLICE_GEN_ABORT_EN adds abort_i to cut a transaction short.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a new request, slice low
// ST_PULSE | slice high for PULSE_CYCLES, counted on its last cycle
// ST_GAP   | slice low for GAP_CYCLES between pulses
// ST_DONE  | one-cycle done strobe, then back to idle
module slice_pulse_gen
    import slice_pkg::*;
#(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [SLICE_W-1:0] count_i,
`ifdef SLICE_GEN_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               ready_o,
    output logic               slice_o,
    output logic [SLICE_W-1:0] sent_o,
    output logic               done_o
);

    localparam logic [PHASE_W-1:0] PULSE_LEN = PHASE_W'(PULSE_CYCLES);
    localparam logic [PHASE_W-1:0] GAP_LEN   = PHASE_W'(GAP_CYCLES);

    slice_gen_state_t   state_q, state_d;
    logic [SLICE_W-1:0] target_q, target_d;
    logic [SLICE_W-1:0] sent_q, sent_d;
    logic [SLICE_W-1:0] req_count;
    logic [SLICE_W-1:0] sent_inc;
    logic               ready_q, slice_q, done_q;
    logic               phase_load;
    logic [PHASE_W-1:0] phase_len;
    logic               phase_last;
    logic               abort_req;

    slice_phase_timer u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (phase_load),
        .len_i  (phase_len),
        .last_o (phase_last)
    );

    assign req_count = clamp_count(count_i);
    assign sent_inc  = sent_q + SLICE_W'(1);

    // Next-state, target/sent updates and phase timer reloads.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        sent_d     = sent_q;
        phase_load = 1'b0;
        phase_len  = PULSE_LEN;
        abort_req  = 1'b0;
`ifdef SLICE_GEN_ABORT_EN
        abort_req  = abort_i;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    target_d = req_count;
                    sent_d   = '0;
                    if (req_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_PULSE;
                        phase_load = 1'b1;
                        phase_len  = PULSE_LEN;
                    end
                end
            end
            ST_PULSE: begin
                // A completing pulse takes priority over abort so it is counted.
                if (phase_last) begin
                    sent_d = sent_inc;
                    if (sent_inc == target_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_GAP;
                        phase_load = 1'b1;
                        phase_len  = GAP_LEN;
                    end
                end else if (abort_req) begin
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (abort_req) begin
                    state_d = ST_DONE;
                end else if (phase_last) begin
                    state_d    = ST_PULSE;
                    phase_load = 1'b1;
                    phase_len  = PULSE_LEN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and outputs registered from the next state so the
    // interface pins come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            sent_q   <= '0;
            ready_q  <= 1'b1;
            slice_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            sent_q   <= sent_d;
            ready_q  <= (state_d == ST_IDLE);
            slice_q  <= (state_d == ST_PULSE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign ready_o = ready_q;
    assign slice_o = slice_q;
    assign sent_o  = sent_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_slice_pulse_gen.sv
// Directed testbench for slice_pulse_gen with hand-computed cycle timelines.
module tb_slice_pulse_gen;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [4:0] count_a, count_b;
    logic       ready_a, slice_a, done_a;
    logic [4:0] sent_a;
    logic       ready_b, slice_b, done_b;
    logic [4:0] sent_b;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    slice_pulse_gen #(.PULSE_CYCLES(1), .GAP_CYCLES(4)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_a),
        .count_i (count_a),
`ifdef SLICE_GEN_ABORT_EN
        .abort_i (1'b0),
`endif
        .ready_o (ready_a),
        .slice_o (slice_a),
        .sent_o  (sent_a),
        .done_o  (done_a)
    );

    slice_pulse_gen #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_b),
        .count_i (count_b),
`ifdef SLICE_GEN_ABORT_EN
        .abort_i (1'b0),
`endif
        .ready_o (ready_b),
        .slice_o (slice_b),
        .sent_o  (sent_b),
        .done_o  (done_b)
    );

`ifdef SLICE_GEN_ABORT_EN
    logic       start_c, abort_c;
    logic [4:0] count_c;
    logic       ready_c, slice_c, done_c;
    logic [4:0] sent_c;

    slice_pulse_gen #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut_c (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_c),
        .count_i (count_c),
        .abort_i (abort_c),
        .ready_o (ready_c),
        .slice_o (slice_c),
        .sent_o  (sent_c),
        .done_o  (done_c)
    );
`endif

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int off = 1; off <= 5; off++) begin
            @(negedge clk);
            total++;
            if ({ready_a, slice_a, sent_a, done_a} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle off=%0d got r=%0b s=%0b sent=%0d d=%0b exp r=1 s=0 sent=0 d=0",
                         off, ready_a, slice_a, sent_a, done_a);
            end
        end
    endtask

    // P=1 G=4, count 3: pulses at +1,+6,+11, done at +12, ready at +13.
    task automatic test_count3();
        logic es, ed, er;
        @(posedge clk); #1;
        start_a = 1'b1; count_a = 5'd3;
        @(posedge clk); #1;
        start_a = 1'b0; count_a = 5'd7;
        for (int off = 1; off <= 13; off++) begin
            @(negedge clk);
            es = (off == 1 || off == 6 || off == 11);
            ed = (off == 12);
            er = (off == 13);
            total++;
            if (slice_a !== es) begin
                bad++;
                $display("FAIL count3_slice off=%0d got=%0b exp=%0b", off, slice_a, es);
            end
            total++;
            if (done_a !== ed) begin
                bad++;
                $display("FAIL count3_done off=%0d got=%0b exp=%0b", off, done_a, ed);
            end
            total++;
            if (ready_a !== er) begin
                bad++;
                $display("FAIL count3_ready off=%0d got=%0b exp=%0b", off, ready_a, er);
            end
            if (off == 6) begin
                total++;
                if (sent_a !== 5'd1) begin
                    bad++;
                    $display("FAIL count3_sent_mid got=%0d exp=1", sent_a);
                end
            end
            if (off == 12 || off == 13) begin
                total++;
                if (sent_a !== 5'd3) begin
                    bad++;
                    $display("FAIL count3_sent_end off=%0d got=%0d exp=3", off, sent_a);
                end
            end
        end
    endtask

    task automatic test_count0();
        @(posedge clk); #1;
        start_a = 1'b1; count_a = 5'd0;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        total++;
        if ({ready_a, slice_a, sent_a, done_a} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL count0_done got r=%0b s=%0b sent=%0d d=%0b exp r=0 s=0 sent=0 d=1",
                     ready_a, slice_a, sent_a, done_a);
        end
        @(negedge clk);
        total++;
        if ({ready_a, slice_a, sent_a, done_a} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL count0_idle got r=%0b s=%0b sent=%0d d=%0b exp r=1 s=0 sent=0 d=0",
                     ready_a, slice_a, sent_a, done_a);
        end
    endtask

    // P=2 G=1, count 25 clamps to 16: latency 16*2+15*1+1 = 48.
    task automatic test_clamp();
        logic prev;
        int   run, rises, highs, done_off, loop_cnt;
        prev = 1'b0; run = 0; rises = 0; highs = 0; done_off = -1; loop_cnt = 0;
        @(posedge clk); #1;
        start_b = 1'b1; count_b = 5'd25;
        @(posedge clk); #1;
        start_b = 1'b0; count_b = 5'd1;
        for (int off = 1; off <= 55; off++) begin
            @(negedge clk);
            if (slice_b === 1'b1) begin
                highs++;
                run++;
                if (!prev) begin
                    rises++;
                    loop_cnt++;
                end
            end else if (prev) begin
                total++;
                if (run != 2) begin
                    bad++;
                    $display("FAIL clamp_width off=%0d got=%0d exp=2", off, run);
                end
                run = 0;
            end
            if (done_b === 1'b1 && done_off < 0) done_off = off;
            prev = slice_b;
        end
        total++;
        if (rises != 16) begin bad++; $display("FAIL clamp_pulses got=%0d exp=16", rises); end
        total++;
        if (highs != 32) begin bad++; $display("FAIL clamp_high_cycles got=%0d exp=32", highs); end
        total++;
        if (done_off != 48) begin bad++; $display("FAIL clamp_done_latency got=%0d exp=48", done_off); end
        total++;
        if (sent_b !== 5'd16) begin bad++; $display("FAIL clamp_sent got=%0d exp=16", sent_b); end
        total++;
        if (loop_cnt != 16) begin bad++; $display("FAIL clamp_loop_counter got=%0d exp=16", loop_cnt); end
        total++;
        if (ready_b !== 1'b1) begin bad++; $display("FAIL clamp_ready got=%0b exp=1", ready_b); end
    endtask

    // start held high, count 2, P=1 G=4: period 8 cycles.
    task automatic test_back_to_back();
        logic es, ed, er;
        int   m;
        @(posedge clk); #1;
        start_a = 1'b1; count_a = 5'd2;
        @(posedge clk); #1;
        for (int off = 1; off <= 24; off++) begin
            @(negedge clk);
            m  = off % 8;
            es = (m == 1 || m == 6);
            ed = (m == 7);
            er = (m == 0);
            total++;
            if ({slice_a, done_a, ready_a} !== {es, ed, er}) begin
                bad++;
                $display("FAIL b2b off=%0d got s=%0b d=%0b r=%0b exp s=%0b d=%0b r=%0b",
                         off, slice_a, done_a, ready_a, es, ed, er);
            end
        end
        start_a = 1'b0;
        @(negedge clk);
        total++;
        if ({slice_a, ready_a, sent_a} !== {1'b0, 1'b1, 5'd2}) begin
            bad++;
            $display("FAIL b2b_end got s=%0b r=%0b sent=%0d exp s=0 r=1 sent=2", slice_a, ready_a, sent_a);
        end
    endtask

    // Count 5, P=1 G=4: reset asserted at +8 (gap after pulse 2).
    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        @(posedge clk); #1;
        start_a = 1'b1; count_a = 5'd5;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int off = 1; off <= 7; off++) @(negedge clk);
        total++;
        if (sent_a !== 5'd2) begin bad++; $display("FAIL rstmid_pre_sent got=%0d exp=2", sent_a); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({ready_a, slice_a, sent_a, done_a} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_outputs got r=%0b s=%0b sent=%0d d=%0b exp r=1 s=0 sent=0 d=0",
                     ready_a, slice_a, sent_a, done_a);
        end
        for (int off = 0; off < 20; off++) begin
            @(negedge clk);
            if (done_a === 1'b1 || slice_a === 1'b1) spurious++;
        end
        total++;
        if (spurious != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d exp=0", spurious); end
    endtask

    task automatic test_rst_start();
        @(posedge clk); #1;
        rst = 1'b1; start_a = 1'b1; count_a = 5'd3;
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0;
        @(negedge clk);
        total++;
        if ({ready_a, slice_a, done_a} !== {1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_start_a got r=%0b s=%0b d=%0b exp r=1 s=0 d=0", ready_a, slice_a, done_a);
        end
        @(negedge clk);
        total++;
        if ({ready_a, slice_a, done_a} !== {1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_start_b got r=%0b s=%0b d=%0b exp r=1 s=0 d=0", ready_a, slice_a, done_a);
        end
    endtask

`ifdef SLICE_GEN_ABORT_EN
    // P=3 G=2, count 5: pulse 3 starts at +11, abort during +12.
    task automatic test_abort();
        @(posedge clk); #1;
        start_c = 1'b1; count_c = 5'd5;
        @(posedge clk); #1;
        start_c = 1'b0;
        for (int off = 1; off <= 11; off++) @(negedge clk);
        @(posedge clk); #1;
        abort_c = 1'b1;
        @(negedge clk);
        total++;
        if (slice_c !== 1'b1) begin bad++; $display("FAIL abort_pre_slice got=%0b exp=1", slice_c); end
        @(posedge clk); #1;
        abort_c = 1'b0;
        @(negedge clk);
        total++;
        if ({slice_c, done_c, sent_c} !== {1'b0, 1'b1, 5'd2}) begin
            bad++;
            $display("FAIL abort_done got s=%0b d=%0b sent=%0d exp s=0 d=1 sent=2", slice_c, done_c, sent_c);
        end
        @(negedge clk);
        total++;
        if ({ready_c, done_c} !== {1'b1, 1'b0}) begin
            bad++;
            $display("FAIL abort_idle got r=%0b d=%0b exp r=1 d=0", ready_c, done_c);
        end
        // Abort on the final pulse cycle: pulse completes and is counted.
        @(posedge clk); #1;
        start_c = 1'b1; count_c = 5'd1;
        @(posedge clk); #1;
        start_c = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_c = 1'b1;
        @(posedge clk); #1;
        abort_c = 1'b0;
        @(negedge clk);
        total++;
        if ({slice_c, done_c, sent_c} !== {1'b0, 1'b1, 5'd1}) begin
            bad++;
            $display("FAIL abort_last got s=%0b d=%0b sent=%0d exp s=0 d=1 sent=1", slice_c, done_c, sent_c);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        start_a = 1'b0; count_a = '0;
        start_b = 1'b0; count_b = '0;
`ifdef SLICE_GEN_ABORT_EN
        start_c = 1'b0; count_c = '0; abort_c = 1'b0;
`endif
        test_reset();
        test_count3();
        test_count0();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_rst_start();
`ifdef SLICE_GEN_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
